msg_char_feeder: RTL and testbench

MSG_CHAR_FEEDER -- requirements
Module: msg_char_feeder

---
 rtl/msg_char_feeder.sv | 154 +++++++++++++++
 tb/tb_msg_char_feeder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_char_feeder.sv
// Buffers keyboard characters in a circular FIFO and feeds them one at a time to a CharSender.
// Optional inter-character idle gap is compiled in with FEEDER_CHAR_GAP_EN.
module msg_char_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                     cclk,
    input  logic                     rstb,
    input  logic                     wr_en,
    input  logic [7:0]               wr_char,
    input  logic                     start,
    input  logic                     done_reading,
    output logic                     send_ena,
    output logic [7:0]               char,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     msg_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 ||
        GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_param_check
        $error("msg_char_feeder: DEPTH or GAP_CYCLES out of range");
    end

`ifdef FEEDER_CHAR_GAP_EN
    typedef enum logic [1:0] {StIdle, StLoad, StSend, StGap} state_e;
    logic [7:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;
`endif

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      char_q, char_d;
    logic            send_ena_q, send_ena_d;
    logic            msg_done_q, msg_done_d;
    logic            push, pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign char     = char_q;
    assign send_ena = send_ena_q;
    assign msg_done = msg_done_q;
    assign busy     = (state_q != StIdle);

    // A write against a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push = wr_en && !full;

    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        send_ena_d = 1'b0;
        msg_done_d = 1'b0;
        pop        = 1'b0;
`ifdef FEEDER_CHAR_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            StIdle: begin
                if (start && !empty) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                pop     = 1'b1;
                char_d  = mem_q[rd_ptr_q];
                state_d = StSend;
            end
            StSend: begin
                send_ena_d = 1'b1;
                // The consumer only acknowledges a character it has actually seen offered.
                if (send_ena_q && done_reading) begin
                    send_ena_d = 1'b0;
                    if (count_q == '0) begin
                        state_d    = StIdle;
                        msg_done_d = 1'b1;
                    end else begin
`ifdef FEEDER_CHAR_GAP_EN
                        state_d = StGap;
                        gap_d   = 8'(GAP_CYCLES - 1);
`else
                        state_d = StLoad;
`endif
                    end
                end
            end
`ifdef FEEDER_CHAR_GAP_EN
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StLoad;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            char_q     <= 8'h00;
            send_ena_q <= 1'b0;
            msg_done_q <= 1'b0;
`ifdef FEEDER_CHAR_GAP_EN
            gap_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            char_q     <= char_d;
            send_ena_q <= send_ena_d;
            msg_done_q <= msg_done_d;
`ifdef FEEDER_CHAR_GAP_EN
            gap_q      <= gap_d;
`endif
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge cclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_char;
        end
    end

endmodule

// File: tb/tb_msg_char_feeder.sv
// Self-checking bench for msg_char_feeder: directed tables/sequences plus randomized traffic
// checked every cycle against a queue-based message model.
module tb_msg_char_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned GAP   = 8;
`ifdef FEEDER_CHAR_GAP_EN
    localparam int unsigned LOAD_DLY = GAP + 1;
`else
    localparam int unsigned LOAD_DLY = 1;
`endif

    logic                   cclk = 1'b0;
    logic                   rstb, wr_en, start, done_reading;
    logic [7:0]             wr_char;
    logic                   send_ena, full, empty, busy, msg_done;
    logic [7:0]             ch;
    logic [$clog2(DEPTH):0] count;

    always #5 cclk = ~cclk;

    msg_char_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .cclk(cclk), .rstb(rstb), .wr_en(wr_en), .wr_char(wr_char), .start(start),
        .done_reading(done_reading), .send_ena(send_ena), .char(ch), .full(full),
        .empty(empty), .count(count), .busy(busy), .msg_done(msg_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Message model: buffered chars, whether a message is active, the char being offered,
    // and countdowns to the next buffer pop / offer derived from the documented latencies.
    logic [7:0] q_m [$];
    logic [7:0] cur_m;
    bit         active_m, sena_m, mdone_m;
    int         pop_dly, sena_dly;

    typedef struct {
        logic [7:0] ch;
        int         exp_cnt;
        bit         exp_full;
    } fill_vec_t;
    fill_vec_t tbl [DEPTH + 2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        cur_m    = 8'h00;
        active_m = 1'b0;
        sena_m   = 1'b0;
        mdone_m  = 1'b0;
        pop_dly  = 0;
        sena_dly = 0;
    endtask

    task automatic model_edge();
        int  pre_size;
        bit  trig;
        pre_size = q_m.size();
        trig     = 1'b0;
        mdone_m  = 1'b0;
        if (!active_m && start && pre_size > 0) begin
            active_m = 1'b1;
            trig     = 1'b1;
        end else if (active_m && sena_m && done_reading) begin
            sena_m = 1'b0;
            if (pre_size == 0) begin
                active_m = 1'b0;
                mdone_m  = 1'b1;
            end else begin
                trig = 1'b1;
            end
        end
        if (pop_dly == 1 && q_m.size() > 0) cur_m = q_m.pop_front();
        if (pop_dly > 0) pop_dly--;
        if (sena_dly == 1) sena_m = 1'b1;
        if (sena_dly > 0) sena_dly--;
        if (wr_en && pre_size < DEPTH) q_m.push_back(wr_char);
        if (trig) begin
            pop_dly  = LOAD_DLY;
            sena_dly = LOAD_DLY + 1;
        end
    endtask

    task automatic check_all();
        chk("count", count, q_m.size());
        chk("full", full, q_m.size() == DEPTH);
        chk("empty", empty, q_m.size() == 0);
        chk("busy", busy, active_m);
        chk("msg_done", msg_done, mdone_m);
        chk("send_ena", send_ena, sena_m);
        chk("char", ch, cur_m);
    endtask

    task automatic tick();
        @(posedge cclk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wait_sena(input int budget, output int waited);
        waited = 0;
        while (send_ena !== 1'b1 && waited < budget) begin
            tick();
            waited++;
        end
        if (send_ena !== 1'b1) chk("sena_timeout", send_ena, 1);
    endtask

    task automatic send_one(input logic [7:0] exp, output int waited);
        wait_sena(40, waited);
        chk("sent_char", ch, exp);
        done_reading = 1'b1;
        tick();
        done_reading = 1'b0;
        chk("sena_drop", send_ena, 0);
    endtask

    task automatic write_char(input logic [7:0] c);
        wr_en   = 1'b1;
        wr_char = c;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        int w;
        int budget;
        logic [7:0] sos [3];
        sos = '{8'h53, 8'h4F, 8'h53};

        rstb = 1'b0; wr_en = 1'b0; wr_char = 8'h00; start = 1'b0; done_reading = 1'b0;
        model_reset();
        repeat (2) @(posedge cclk);
        #1;
        chk("rst_sena", send_ena, 0);
        chk("rst_char", ch, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        rstb = 1'b1;

        // "SOS" message
        foreach (sos[i]) write_char(sos[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_one(sos[i], w);
            chk("latency", w, LOAD_DLY + 1);
        end
        chk("sos_msg_done", msg_done, 1);
        tick();
        chk("sos_msg_done_pulse", msg_done, 0);
        chk("sos_busy", busy, 0);
        chk("sos_empty", empty, 1);

        // Overfill: last two writes dropped, then drain in order across the pointer wrap
        for (int i = 0; i < DEPTH + 2; i++) begin
            tbl[i].ch       = 8'h60 + 8'(i);
            tbl[i].exp_cnt  = (i + 1 < DEPTH) ? i + 1 : DEPTH;
            tbl[i].exp_full = (i + 1 >= DEPTH);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            write_char(tbl[i].ch);
            chk("fill_count", count, tbl[i].exp_cnt);
            chk("fill_full", full, tbl[i].exp_full);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        // Full FIFO popping on this edge must still drop the write
        wr_en = 1'b1; wr_char = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("full_pop_drop", count, DEPTH - 1);
        for (int i = 0; i < DEPTH; i++) send_one(tbl[i].ch, w);
        chk("fill_msg_done", msg_done, 1);
        tick();

        // start with empty FIFO and done_reading while idle are ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_busy", busy, 0);
        done_reading = 1'b1;
        repeat (2) tick();
        done_reading = 1'b0;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_sena", send_ena, 0);
        chk("idle_done_mdone", msg_done, 0);

        // Write lands on the same edge as the final done_reading
        write_char(8'h41);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sena(40, w);
        chk("late_char_a", ch, 8'h41);
        wr_en = 1'b1; wr_char = 8'h42; done_reading = 1'b1;
        tick();
        wr_en = 1'b0; done_reading = 1'b0;
        chk("late_msg_done", msg_done, 1);
        chk("late_count", count, 1);
        tick();
        chk("late_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_one(8'h42, w);
        chk("late_msg_done2", msg_done, 1);
        tick();

        // Asynchronous reset mid-SEND with characters buffered
        for (int i = 0; i < 4; i++) write_char(8'h30 + 8'(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sena(40, w);
        #2;
        rstb = 1'b0;
        #1;
        chk("arst_sena", send_ena, 0);
        chk("arst_char", ch, 8'h00);
        chk("arst_count", count, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        @(posedge cclk);
        #1;
        rstb = 1'b1;
        write_char(8'h5A);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_one(8'h5A, w);
        chk("post_rst_latency", w, LOAD_DLY + 1);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            wr_en        = ($urandom_range(0, 2) == 0);
            wr_char      = 8'($urandom);
            start        = ($urandom_range(0, 7) == 0);
            done_reading = send_ena && ($urandom_range(0, 2) == 0);
            tick();
        end
        budget = 0;
        wr_en  = 1'b0;
        while ((busy || !empty) && budget < 3000) begin
            start        = !busy && !empty;
            done_reading = send_ena;
            tick();
            budget++;
        end
        start = 1'b0; done_reading = 1'b0;
        chk("drain_idle", {busy, empty}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
